// File: rtl/cla16_seq_adder_if.sv
// Requester <-> sequential adder bus: start/done handshake, operands and result.
// Latency: none, wires only; timing is set by the adder behind the slave modport.
// Backpressure: start is only honoured while the adder is not busy.
// Optional macro CLA_SEQ_SUB_EN adds the subtract-select signal 'sub'.
// Signals: start, a, b, cin, [sub] driven by master; busy, done, sum, cout, ovf driven by slave.
interface cla16_seq_adder_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef CLA_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
`ifdef CLA_SEQ_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla16_seq_adder.sv
// WORDS*16-bit adder built by stepping one 16-bit carry-lookahead slice per cycle.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WORDS.
// Backpressure: start is ignored while busy; a start in the done cycle is taken with no bubble.
// Optional macro CLA_SEQ_SUB_EN: sub=1 on accept computes a-b (b inverted, carry-in forced 1).
// Ports: clk_i clock, rst_i synchronous active-high reset, bus (cla16_seq_adder_if.slave).
// WORDS legal range is 2..16.

// 16-bit two-level carry-lookahead adder: four 4-bit groups, lookahead across groups.
module CLA_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        // Group carries are fully flattened so no group waits on its neighbour.
        gc[0] = c_i;
        gc[1] = gg[0] | (gp[0] & c_i);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_i);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        s_o = p ^ c;
        c_o = gc[4];
    end
endmodule

module cla16_seq_adder #(
    parameter int WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cla16_seq_adder_if.slave      bus
);
    localparam int W    = 16 * WORDS;
    localparam int IDXW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_op_q, a_op_d;
    logic [W-1:0]      b_op_q, b_op_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              start_acc;
    logic              last_slice;
    logic [15:0]       cla_a;
    logic [15:0]       cla_b;
    logic [15:0]       cla_sum;
    logic              cla_cout;
    logic              busy_w;
    logic              done_w;

    assign start_acc  = bus.start && (state_q == IDLE || state_q == DONE);
    assign last_slice = (idx_q == IDXW'(WORDS - 1));

    // Slice base is idx*16, formed by concatenation to keep widths exact.
    assign cla_a = a_op_q[{idx_q, 4'b0000} +: 16];
    assign cla_b = b_op_q[{idx_q, 4'b0000} +: 16];

    CLA_16bit u_cla (
        .a_i (cla_a),
        .b_i (cla_b),
        .c_i (carry_q),
        .s_o (cla_sum),
        .c_o (cla_cout)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? RUN : IDLE;
            RUN:     state_d = last_slice ? DONE : RUN;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy_w = (state_q == RUN);
        done_w = (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        a_op_d  = a_op_q;
        b_op_d  = b_op_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (start_acc) begin
            a_op_d = bus.a;
            idx_d  = '0;
`ifdef CLA_SEQ_SUB_EN
            // a - b == a + ~b + 1; cin is ignored for subtraction.
            b_op_d  = bus.sub ? ~bus.b : bus.b;
            carry_d = bus.sub ? 1'b1 : bus.cin;
`else
            b_op_d  = bus.b;
            carry_d = bus.cin;
`endif
        end else if (state_q == RUN) begin
            sum_d[{idx_q, 4'b0000} +: 16] = cla_sum;
            carry_d = cla_cout;
            if (last_slice) begin
                cout_d = cla_cout;
                // b_op already holds the effective (possibly inverted) operand.
                ovf_d  = (a_op_q[W-1] == b_op_q[W-1]) && (cla_sum[15] != a_op_q[W-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_op_q  <= '0;
            b_op_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_op_q  <= a_op_d;
            b_op_q  <= b_op_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_w;
    assign bus.done = done_w;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cla16_seq_adder.sv
// Bench for cla16_seq_adder with WORDS=4: directed vector table plus hand-written
// sequences for ignored start, mid-run reset, back-to-back start and reset/start collision.
// Define CLA_SEQ_SUB_EN to add the subtraction vectors.
module tb_cla16_seq_adder;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla16_seq_adder_if #(.WORDS(WORDS)) bus ();

    cla16_seq_adder #(.WORDS(WORDS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs so only
    // the latched copies can produce the right answer. Returns in the first RUN cycle.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic c);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.cin   = ~c;
    endtask

    task automatic wait_done(input string name, output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (bus.done !== 1'b1 && cyc < 50) begin
            if (bus.busy === 1'b1) bc++;
            tick();
            cyc++;
        end
        chk({name, "_done_seen"}, {63'd0, bus.done}, 64'd1);
    endtask

    task automatic finish_op(input string name, input logic [63:0] s,
                             input logic co, input logic ov);
        int cyc;
        int bc;
        wait_done(name, cyc, bc);
        chk({name, "_latency"}, 64'(cyc), 64'(WORDS));
        chk({name, "_busy_cycles"}, 64'(bc), 64'(WORDS));
        chk({name, "_sum"}, bus.sum, s);
        chk({name, "_cout"}, {63'd0, bus.cout}, {63'd0, co});
        chk({name, "_ovf"}, {63'd0, bus.ovf}, {63'd0, ov});
    endtask

    initial begin
        int   cyc;
        int   bc;
        logic saw_done;

        // Reset with start held high: reset must win.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 64'h1234;
        bus.b     = 64'h5678;
        bus.cin   = 1'b1;
`ifdef CLA_SEQ_SUB_EN
        bus.sub   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_sum",  bus.sum, 64'd0);
        chk("rst_cout", {63'd0, bus.cout}, 64'd0);
        chk("rst_ovf",  {63'd0, bus.ovf}, 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();

        //            a                       b                       cin   sub   sum                     cout  ovf
        vq.push_back('{64'h0000_0000_0000_03cd, 64'h0000_0000_0000_0701, 1'b0, 1'b0, 64'h0000_0000_0000_0ace, 1'b0, 1'b0});
        vq.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0});
        vq.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vq.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b1});
        vq.push_back('{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 64'h2222_2222_2222_2212, 1'b0, 1'b0});
        vq.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0});
`ifdef CLA_SEQ_SUB_EN
        vq.push_back('{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        vq.push_back('{64'h0000_0000_0000_0007, 64'h0000_0000_0000_0005, 1'b0, 1'b1, 64'h0000_0000_0000_0002, 1'b1, 1'b0});
        vq.push_back('{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
`endif

        for (int i = 0; i < vq.size(); i++) begin
`ifdef CLA_SEQ_SUB_EN
            bus.sub = vq[i].sub;
`endif
            issue(vq[i].a, vq[i].b, vq[i].cin);
`ifdef CLA_SEQ_SUB_EN
            bus.sub = 1'b0;
`endif
            finish_op($sformatf("v%0d", i), vq[i].sum, vq[i].cout, vq[i].ovf);
            tick();
            chk($sformatf("v%0d_done_pulse", i), {63'd0, bus.done}, 64'd0);
            chk($sformatf("v%0d_sum_held", i), bus.sum, vq[i].sum);
        end

        // Start re-pulsed with new operands during RUN is ignored.
        issue(64'h03cd, 64'h0701, 1'b0);
        tick();
        bus.a     = 64'hDEAD_BEEF_0000_1111;
        bus.b     = 64'h0000_0000_0000_1234;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("ign", cyc, bc);
        chk("ign_latency", 64'(cyc + 2), 64'(WORDS));
        chk("ign_sum", bus.sum, 64'h0ace);
        chk("ign_cout", {63'd0, bus.cout}, 64'd0);
        tick();
        chk("ign_done_pulse", {63'd0, bus.done}, 64'd0);

        // Reset in the second RUN cycle aborts with no done pulse.
        issue(64'h1111_1111_1111_1111, 64'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_sum",  bus.sum, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);

        // A new start after the abort completes normally.
        issue(64'h0001_0000_0000_FFFF, 64'h1, 1'b0);
        finish_op("post_abort", 64'h0001_0000_0001_0000, 1'b0, 1'b0);

        // Start in the done cycle is taken without a bubble.
        issue(64'h5, 64'h7, 1'b0);
        chk("b2b_busy", {63'd0, bus.busy}, 64'd1);
        chk("b2b_done", {63'd0, bus.done}, 64'd0);
        finish_op("b2b", 64'h000C, 1'b0, 1'b0);
        tick();

        // Reset and start on the same edge from IDLE: reset wins.
        bus.start = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_start_sum", bus.sum, 64'd0);
        tick();
        chk("rst_start_idle", {63'd0, bus.busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
